rr_arbiter_mux: RTL and testbench
=================================

// Module: rr_arbiter_mux
// PURPOSE
//  5-way round-robin arbiter with a grant-driven 5:1 data mux, used in each router
//  output controller. Ports: East(0) North(1) West(2) South(3) Local(4).
//  Input controllers raise requests. The arbiter issues one registered one-hot grant.
//  The mux forwards the granted port's packet to the output register stage.
// PARAMETERS
//  dataWidth  32  width of every packet bus
// PORTS
//  clock           in   1          single clock, rising edge
//  rst             in   1          asynchronous, active-high reset
//  req0..req4      in   1 each     request from input controller of port n
//  gnt0..gnt4      out  1 each     registered grant to port n, one-hot or all zero
//  PacketInPort_0..PacketInPort_4  in  dataWidth each  packet offered by port n
//  PacketOut       out  dataWidth  packet of the selected port (combinational)
// BEHAVIOUR
//  Reset:
//  - rst=1 forces gnt0..gnt4=0 and the priority pointer ptr=4 immediately.
//    Port 0 therefore has first priority after reset.
//  - Reset asserted mid-grant drops the grant at once, without waiting for a clock edge.
//  Arbitration, evaluated at each rising clock edge:
//  - Hold: if a grant is held and that port's req is still 1, the grant is unchanged.
//    There is no timeout.
//  - Otherwise the arbiter searches ports ptr+1, ptr+2 ... ptr+5 (mod 5).
//    The first port with req=1 gets gnt=1 and ptr is set to that port.
//  - If no port requests, all grants are 0 and ptr is unchanged.
//  - Release: when the holder drops req, the next edge grants the next requester in
//    rotation, with no idle cycle.
//  Latency and signal rules:
//  - A grant appears on the first rising edge where req is seen high. Latency is 1 clock.
//  - At most one gnt is high at any time. A grant is never given to a port with req=0
//    at the sampling edge.
//  - Simultaneous requests are resolved by rotation only. Each requester is served
//    within 5 grant rounds (fairness).
//  Mux select:
//  - sel[2:0] = {gnt4, gnt3|gnt2, gnt3|gnt1}.
//  - sel 0..4 selects PacketInPort_0..PacketInPort_4.
//  - sel 5..7 (unreachable) drive PacketOut to all zeros.
//  - With no grant, sel=0 and PacketInPort_0 is passed through. The consumer must
//    qualify PacketOut with the OR of the grants.
//  - PacketOut follows the data inputs combinationally. The block has no data register.
//  Upstream masking:
//  - The parent gates requests (FIFO full or busy) before this block.
//  - Masked requests behave as req=0: the grant drops on the next edge.
// TESTING
//  1. Reset: assert rst with req=5'b11111 -> all gnt=0, PacketOut=PacketInPort_0.
//     Release rst -> gnt0=1 on the next edge.
//  2. Single request: req2=1 only, PacketInPort_2=32'hA5A5_0002 ->
//     one edge later gnt2=1 and PacketOut=32'hA5A5_0002. Grant holds while req2=1.
//  3. Rotation: all req=1, each holder drops req for one cycle after its grant ->
//     grant order 0,1,2,3,4,0. Exactly one gnt high at every cycle.
//  4. Skip idle ports: ptr=1, req={req4=1, req0=1} -> gnt4 first,
//     then gnt0 after req4 drops.
//  5. Async reset mid-grant: gnt3=1, pulse rst between edges ->
//     gnt3 goes low without a clock edge and the next grant restarts from port 0.
//  6. Mux map: drive distinct values 32'h0..32'h4 on the five ports and force each
//     grant -> PacketOut equals the granted port's value. With no grant, PacketOut=32'h0.

Source files
------------

// File: rtl/rr_arbiter_mux.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter_mux
// Description : 5-way round-robin arbiter with a registered one-hot grant.
//               A grant-driven 5:1 mux forwards the winning port's packet.
//               Ports: East(0) North(1) West(2) South(3) Local(4).
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter_mux #(
  parameter int dataWidth = 32
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic                 req0,
  input  logic                 req1,
  input  logic                 req2,
  input  logic                 req3,
  input  logic                 req4,
  output logic                 gnt0,
  output logic                 gnt1,
  output logic                 gnt2,
  output logic                 gnt3,
  output logic                 gnt4,
  input  logic [dataWidth-1:0] PacketInPort_0,
  input  logic [dataWidth-1:0] PacketInPort_1,
  input  logic [dataWidth-1:0] PacketInPort_2,
  input  logic [dataWidth-1:0] PacketInPort_3,
  input  logic [dataWidth-1:0] PacketInPort_4,
  output logic [dataWidth-1:0] PacketOut
);

  localparam logic [2:0] c_ptr_reset = 3'd4;

  logic [4:0] req;
  logic [4:0] gnt;
  logic [4:0] gnt_nxt;
  logic [2:0] ptr;
  logic [2:0] ptr_nxt;
  logic [3:0] search_sum;
  logic [2:0] search_idx;
  logic       found;
  logic [2:0] sel;

  assign req = {req4, req3, req2, req1, req0};

  assign gnt0 = gnt[0];
  assign gnt1 = gnt[1];
  assign gnt2 = gnt[2];
  assign gnt3 = gnt[3];
  assign gnt4 = gnt[4];

  // Next grant: keep the holder while it still requests, otherwise scan
  // ptr+1 .. ptr+5 (mod 5) and take the first requester.
  always_comb begin
    gnt_nxt    = '0;
    ptr_nxt    = ptr;
    search_sum = '0;
    search_idx = '0;
    found      = 1'b0;
    if (|(gnt & req)) begin
      gnt_nxt = gnt;
    end else begin
      for (int k = 1; k <= 5; k++) begin
        search_sum = {1'b0, ptr} + 4'(k);
        if (search_sum >= 4'd5) begin
          search_sum = search_sum - 4'd5;
        end
        search_idx = search_sum[2:0];
        if (!found && req[search_idx]) begin
          found               = 1'b1;
          gnt_nxt[search_idx] = 1'b1;
          ptr_nxt             = search_idx;
        end
      end
    end
  end

  // Grant and priority pointer registers; reset clears grants at once.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      gnt <= '0;
      ptr <= c_ptr_reset;
    end else begin
      gnt <= gnt_nxt;
      ptr <= ptr_nxt;
    end
  end

  // Select is encoded directly from the one-hot grant; no grant gives sel=0.
  assign sel = {gnt[4], gnt[3] | gnt[2], gnt[3] | gnt[1]};

  // Unregistered data path: the consumer qualifies it with the grants.
  always_comb begin
    PacketOut = '0;
    case (sel)
      3'd0:    PacketOut = PacketInPort_0;
      3'd1:    PacketOut = PacketInPort_1;
      3'd2:    PacketOut = PacketInPort_2;
      3'd3:    PacketOut = PacketInPort_3;
      3'd4:    PacketOut = PacketInPort_4;
      default: PacketOut = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter_mux.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_arbiter_mux
// Description : Self-checking bench for rr_arbiter_mux with a round-robin
//               reference model based on a holder index and a pointer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_arbiter_mux;

  logic        clock;
  logic        rst;
  logic [4:0]  req;
  logic [4:0]  gnt;
  logic [31:0] din [5];
  logic [31:0] PacketOut;

  int checks;
  int errors;

  // Reference model state: which port holds the grant (-1 = none) and pointer.
  int m_holder;
  int m_ptr;

  rr_arbiter_mux #(.dataWidth(32)) dut (
    .clock          (clock),
    .rst            (rst),
    .req0           (req[0]),
    .req1           (req[1]),
    .req2           (req[2]),
    .req3           (req[3]),
    .req4           (req[4]),
    .gnt0           (gnt[0]),
    .gnt1           (gnt[1]),
    .gnt2           (gnt[2]),
    .gnt3           (gnt[3]),
    .gnt4           (gnt[4]),
    .PacketInPort_0 (din[0]),
    .PacketInPort_1 (din[1]),
    .PacketInPort_2 (din[2]),
    .PacketInPort_3 (din[3]),
    .PacketInPort_4 (din[4]),
    .PacketOut      (PacketOut)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [4:0] exp_gnt();
    return (m_holder >= 0) ? (5'b00001 << m_holder) : 5'b00000;
  endfunction

  function automatic logic [31:0] exp_out();
    return (m_holder >= 0) ? din[m_holder] : din[0];
  endfunction

  // One rising edge: advance the model using req as seen at the edge,
  // then return at the following falling edge for sampling.
  task automatic tick();
    @(posedge clock);
    if (!(m_holder >= 0 && req[m_holder])) begin
      m_holder = -1;
      for (int k = 1; k <= 5; k++) begin
        if (m_holder < 0 && req[(m_ptr + k) % 5]) begin
          m_holder = (m_ptr + k) % 5;
        end
      end
      if (m_holder >= 0) m_ptr = m_holder;
    end
    @(negedge clock);
  endtask

  // Short reset pulse between edges, starting from a falling edge.
  task automatic do_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    m_holder = -1;
    m_ptr    = 4;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 5'b11111;
    m_holder = -1;
    m_ptr    = 4;
    #1;
    checks++;
    if (gnt !== 5'b00000) begin
      errors++;
      $display("FAIL reset_gnt: got %b expected %b", gnt, 5'b00000);
    end
    checks++;
    if (PacketOut !== din[0]) begin
      errors++;
      $display("FAIL reset_out: got %h expected %h", PacketOut, din[0]);
    end
    @(negedge clock);
    rst = 1'b0;
    tick();
    checks++;
    if (gnt !== 5'b00001 || gnt !== exp_gnt()) begin
      errors++;
      $display("FAIL reset_first_grant: got %b expected %b", gnt, 5'b00001);
    end
  endtask

  task automatic test_single();
    do_reset();
    req    = 5'b00100;
    din[2] = 32'hA5A5_0002;
    tick();
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (gnt !== 5'b00100) begin
        errors++;
        $display("FAIL single_gnt cyc%0d: got %b expected %b", c, gnt, 5'b00100);
      end
      checks++;
      if (PacketOut !== 32'hA5A5_0002) begin
        errors++;
        $display("FAIL single_out cyc%0d: got %h expected %h", c, PacketOut, 32'hA5A5_0002);
      end
      if (c < 3) tick();
    end
  endtask

  task automatic test_rotation();
    int order [6];
    int holder;
    order = '{0, 1, 2, 3, 4, 0};
    do_reset();
    req = 5'b11111;
    tick();
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (gnt !== (5'b00001 << order[i]) || gnt !== exp_gnt()) begin
        errors++;
        $display("FAIL rotation step%0d: got %b expected %b", i, gnt, 5'b00001 << order[i]);
      end
      checks++;
      if ($countones(gnt) > 1) begin
        errors++;
        $display("FAIL rotation_onehot step%0d: got %b expected at most one bit", i, gnt);
      end
      holder = order[i];
      req[holder] = 1'b0;
      tick();
      req[holder] = 1'b1;
    end
  endtask

  task automatic test_skip();
    do_reset();
    req = 5'b00010;
    tick();
    req = 5'b10001;
    tick();
    checks++;
    if (gnt !== 5'b10000 || gnt !== exp_gnt()) begin
      errors++;
      $display("FAIL skip_first: got %b expected %b", gnt, 5'b10000);
    end
    req[4] = 1'b0;
    tick();
    checks++;
    if (gnt !== 5'b00001 || gnt !== exp_gnt()) begin
      errors++;
      $display("FAIL skip_second: got %b expected %b", gnt, 5'b00001);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    @(negedge clock);
    req = 5'b01000;
    tick();
    checks++;
    if (gnt !== 5'b01000) begin
      errors++;
      $display("FAIL async_pre: got %b expected %b", gnt, 5'b01000);
    end
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (gnt !== 5'b00000) begin
      errors++;
      $display("FAIL async_drop: got %b expected %b", gnt, 5'b00000);
    end
    #1;
    rst = 1'b0;
    m_holder = -1;
    m_ptr    = 4;
    req = 5'b11111;
    tick();
    checks++;
    if (gnt !== 5'b00001) begin
      errors++;
      $display("FAIL async_restart: got %b expected %b", gnt, 5'b00001);
    end
  endtask

  task automatic test_mux_map();
    for (int i = 0; i < 5; i++) din[i] = 32'(i);
    do_reset();
    req = 5'b00000;
    tick();
    checks++;
    if (PacketOut !== 32'h0 || gnt !== 5'b00000) begin
      errors++;
      $display("FAIL mux_idle: got out=%h gnt=%b expected out=%h gnt=%b", PacketOut, gnt, 32'h0, 5'b00000);
    end
    for (int i = 0; i < 5; i++) begin
      req = 5'b00001 << i;
      tick();
      checks++;
      if (PacketOut !== 32'(i) || gnt !== (5'b00001 << i)) begin
        errors++;
        $display("FAIL mux_port%0d: got out=%h gnt=%b expected out=%h", i, PacketOut, gnt, 32'(i));
      end
      req = 5'b00000;
      tick();
    end
  endtask

  task automatic test_random();
    int served [5];
    do_reset();
    for (int i = 0; i < 5; i++) served[i] = 0;
    for (int c = 0; c < 400; c++) begin
      req = 5'($urandom_range(0, 31));
      tick();
      for (int i = 0; i < 5; i++) din[i] = $urandom;
      #1;
      checks++;
      if (gnt !== exp_gnt()) begin
        errors++;
        $display("FAIL random_gnt cyc%0d: got %b expected %b", c, gnt, exp_gnt());
      end
      checks++;
      if (PacketOut !== exp_out()) begin
        errors++;
        $display("FAIL random_out cyc%0d: got %h expected %h", c, PacketOut, exp_out());
      end
      @(negedge clock);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    req    = 5'b00000;
    for (int i = 0; i < 5; i++) din[i] = 32'h1000_0000 + 32'(i);
    m_holder = -1;
    m_ptr    = 4;
    @(negedge clock);
    test_reset();
    test_single();
    test_rotation();
    test_skip();
    test_async_reset();
    test_mux_map();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
